// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RV32I size codes,
// FSM state encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  // Number of bytes touched by an access; illegal codes fall back to a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_bytes = 3'd1;
      F3_H, F3_HU: access_bytes = 3'd2;
      default:     access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational datapath for the load/store unit: request legality and range
// check, big-endian load formatting and sub-word store merge.
module lsu_lane_unit
  import lsu_pkg::*;
#(
  parameter int A_WIDTH = 28
) (
  input  logic               chk_we,
  input  logic [2:0]         chk_funct3,
  input  logic [A_WIDTH-1:0] chk_addr,
  input  logic [2:0]         funct3,
  input  logic [15:0]        wdata_lo,
  input  logic [31:0]        mem_rd,
  output logic               chk_err,
  output logic [31:0]        load_data,
  output logic [31:0]        merged
);

  logic             legal;
  logic [A_WIDTH:0] last_byte;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    legal = 1'b0;
    case (chk_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !chk_we;
      default:          legal = 1'b0;
    endcase
  end

  // One extra bit so the last byte address of an access can never wrap.
  assign last_byte = {1'b0, chk_addr}
                   + {{(A_WIDTH-2){1'b0}}, access_bytes(chk_funct3)}
                   - {{A_WIDTH{1'b0}}, 1'b1};

  assign chk_err = !legal || last_byte[A_WIDTH];

  always_comb begin
    load_data = mem_rd;
    case (funct3)
      F3_B:    load_data = {{24{mem_rd[31]}}, mem_rd[31:24]};
      F3_BU:   load_data = {24'h000000, mem_rd[31:24]};
      F3_H:    load_data = {{16{mem_rd[31]}}, mem_rd[31:16]};
      F3_HU:   load_data = {16'h0000, mem_rd[31:16]};
      default: load_data = mem_rd;
    endcase
  end

  // Byte at the access address is the MSB of the memory word.
  assign merged = (funct3 == F3_H) ? {wdata_lo, mem_rd[15:0]}
                                   : {wdata_lo[7:0], mem_rd[23:0]};

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a big-endian
// 4-byte-wide DataMemory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int A_WIDTH = 28,
  parameter int D_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WE,
  input  logic [2:0]         REQ_FUNCT3,
  input  logic [A_WIDTH-1:0] REQ_ADDR,
  input  logic [D_WIDTH-1:0] REQ_WDATA,
  output logic               RSP_VALID,
  output logic [D_WIDTH-1:0] RSP_RDATA,
  output logic               RSP_ERR,
  output logic [A_WIDTH-1:0] MEM_A,
  output logic [D_WIDTH-1:0] MEM_WD,
  output logic               MEM_WE,
  input  logic [D_WIDTH-1:0] MEM_RD
);

  lsu_state_t         state_q, state_d;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic [D_WIDTH-1:0] merged_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic               err_q;

  logic               accept;
  logic               chk_err;
  logic [D_WIDTH-1:0] load_data;
  logic [D_WIDTH-1:0] merged;

  assign accept = REQ_VALID && (state_q == S_IDLE);

  lsu_lane_unit #(
    .A_WIDTH (A_WIDTH)
  ) u_lane (
    .chk_we     (REQ_WE),
    .chk_funct3 (REQ_FUNCT3),
    .chk_addr   (REQ_ADDR),
    .funct3     (funct3_q),
    .wdata_lo   (wdata_q[15:0]),
    .mem_rd     (MEM_RD),
    .chk_err    (chk_err),
    .load_data  (load_data),
    .merged     (merged)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= REQ_WE;
        funct3_q <= REQ_FUNCT3;
        addr_q   <= REQ_ADDR;
        wdata_q  <= REQ_WDATA;
        err_q    <= chk_err;
        rdata_q  <= '0;
      end
      if (state_q == S_LOAD)   rdata_q  <= load_data;
      if (state_q == S_RMW_RD) merged_q <= merged;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (chk_err)                 state_d = S_RESP;
          else if (!REQ_WE)            state_d = S_LOAD;
          else if (REQ_FUNCT3 == F3_W) state_d = S_WRITE;
          else                         state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory strobes depend on the state register alone, never on REQ_* inputs.
  always_comb begin
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    MEM_A     = '0;
    MEM_WD    = '0;
    MEM_WE    = 1'b0;
    case (state_q)
      S_IDLE: REQ_READY = 1'b1;
      S_LOAD, S_RMW_RD: MEM_A = addr_q;
      S_WRITE: begin
        MEM_A  = addr_q;
        MEM_WD = (funct3_q == F3_W) ? wdata_q : merged_q;
        MEM_WE = 1'b1;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        RSP_RDATA = we_q ? '0 : rdata_q;
        RSP_ERR   = err_q;
      end
      default: ;
    endcase
  end

endmodule
